// File: rtl/ex_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_issue_pkg / ex_issue_if
// Brief    : ALU opcode type and the decode/forward/ALU bundle of the ID/EX register
// Revision : 1.0 - initial release
// ============================================================================

package ex_issue_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_t;
endpackage

interface ex_issue_if;
    import ex_issue_pkg::*;

    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic        id_use_pc;
    logic        id_use_imm;
    alu_op_t     id_alu_op;
    logic        id_alu_inv_res;
    logic [4:0]  id_rd_addr;
    logic        id_reg_write;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_we;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        alu_insert_bubble;
    logic        flush;
    logic [31:0] left_operand;
    logic [31:0] right_operand;
    alu_op_t     alu_op;
    logic        alu_inv_res;
    logic        ex_valid;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic [31:0] ex_store_data;
    logic        id_stall;

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_use_pc, id_use_imm, id_alu_op, id_alu_inv_res, id_rd_addr,
               id_reg_write, mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we,
               wb_fwd_rd, wb_fwd_data, alu_insert_bubble, flush,
        output left_operand, right_operand, alu_op, alu_inv_res, ex_valid,
               ex_rd_addr, ex_reg_write, ex_store_data, id_stall
    );

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_use_pc, id_use_imm, id_alu_op, id_alu_inv_res, id_rd_addr,
               id_reg_write, mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we,
               wb_fwd_rd, wb_fwd_data, alu_insert_bubble, flush,
        input  left_operand, right_operand, alu_op, alu_inv_res, ex_valid,
               ex_rd_addr, ex_reg_write, ex_store_data, id_stall
    );
endinterface

`default_nettype wire

// File: rtl/ex_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_issue_stage
// Brief    : ID/EX register feeding the ALU; forwards at capture, freezes on ALU bubbles
// Revision : 1.0 - initial release
// ============================================================================

module ex_issue_stage
    import ex_issue_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    ex_issue_if.slave                   bus,
    output logic [STALL_CNT_W-1:0]      stall_cycles
);

    logic [31:0] r_rs1_val;
    logic [31:0] r_rs2_val;
    logic [31:0] r_pc;
    logic [31:0] r_imm;
    logic        r_use_pc;
    logic        r_use_imm;
    alu_op_t     r_alu_op;
    logic        r_inv_res;
    logic        r_valid;
    logic [4:0]  r_rd_addr;
    logic        r_reg_write;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [31:0] w_rs1_fwd;
    logic [31:0] w_rs2_fwd;

    // MEM is younger than WB, so it is checked first.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  addr,
        input logic [31:0] rf_data,
        input logic        mem_we,
        input logic [4:0]  mem_rd,
        input logic [31:0] mem_data,
        input logic        wb_we,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_data
    );
        logic [31:0] v;
        if (addr == 5'd0)
            v = 32'd0;
        else if (mem_we && (mem_rd == addr))
            v = mem_data;
        else if (wb_we && (wb_rd == addr))
            v = wb_data;
        else
            v = rf_data;
        return v;
    endfunction

    always_comb begin
        w_rs1_fwd = fwd_sel(bus.id_rs1_addr, bus.id_rs1_data,
                            bus.mem_fwd_we, bus.mem_fwd_rd, bus.mem_fwd_data,
                            bus.wb_fwd_we, bus.wb_fwd_rd, bus.wb_fwd_data);
        w_rs2_fwd = fwd_sel(bus.id_rs2_addr, bus.id_rs2_data,
                            bus.mem_fwd_we, bus.mem_fwd_rd, bus.mem_fwd_data,
                            bus.wb_fwd_we, bus.wb_fwd_rd, bus.wb_fwd_data);
    end

    // Flush beats the bubble hold so a redirect squashes a stalled MUL at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd_addr   <= 5'd0;
            r_rs1_val   <= 32'd0;
            r_rs2_val   <= 32'd0;
            r_pc        <= 32'd0;
            r_imm       <= 32'd0;
            r_use_pc    <= 1'b0;
            r_use_imm   <= 1'b0;
            r_alu_op    <= ALU_ADD;
            r_inv_res   <= 1'b0;
        end else if (bus.flush || (!bus.alu_insert_bubble && !bus.id_valid)) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd_addr   <= 5'd0;
            r_rs1_val   <= 32'd0;
            r_rs2_val   <= 32'd0;
            r_pc        <= 32'd0;
            r_imm       <= 32'd0;
            r_use_pc    <= 1'b0;
            r_use_imm   <= 1'b0;
            r_alu_op    <= ALU_ADD;
            r_inv_res   <= 1'b0;
        end else if (!bus.alu_insert_bubble) begin
            r_valid     <= 1'b1;
            r_reg_write <= bus.id_reg_write;
            r_rd_addr   <= bus.id_rd_addr;
            r_rs1_val   <= w_rs1_fwd;
            r_rs2_val   <= w_rs2_fwd;
            r_pc        <= bus.id_pc;
            r_imm       <= bus.id_imm;
            r_use_pc    <= bus.id_use_pc;
            r_use_imm   <= bus.id_use_imm;
            r_alu_op    <= bus.id_alu_op;
            r_inv_res   <= bus.id_alu_inv_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (bus.alu_insert_bubble && (r_stall_cnt != {STALL_CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign bus.left_operand  = r_use_pc  ? r_pc  : r_rs1_val;
    assign bus.right_operand = r_use_imm ? r_imm : r_rs2_val;
    assign bus.ex_store_data = r_rs2_val;
    assign bus.alu_op        = r_alu_op;
    assign bus.alu_inv_res   = r_inv_res;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_rd_addr    = r_rd_addr;
    assign bus.ex_reg_write  = r_reg_write & r_valid;
    assign bus.id_stall      = bus.alu_insert_bubble;
    assign stall_cycles      = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ex_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_issue_stage
// Brief    : Directed self-checking bench for the ID/EX issue register
// Revision : 1.0 - initial release
// ============================================================================

module tb_ex_issue_stage;
    import ex_issue_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] stall_cycles;
    logic [3:0]  stall_sat;
    int          n_tests;
    int          n_fail;

    ex_issue_if bus ();
    ex_issue_if bus_sat ();

    ex_issue_stage #(.STALL_CNT_W(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .stall_cycles (stall_cycles)
    );

    ex_issue_stage #(.STALL_CNT_W(4)) u_dut_sat (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_sat),
        .stall_cycles (stall_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0;
        bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_use_pc = 0;
        bus.id_use_imm = 0; bus.id_alu_op = ALU_ADD; bus.id_alu_inv_res = 0;
        bus.id_rd_addr = 0; bus.id_reg_write = 0; bus.mem_fwd_we = 0; bus.mem_fwd_rd = 0;
        bus.mem_fwd_data = 0; bus.wb_fwd_we = 0; bus.wb_fwd_rd = 0; bus.wb_fwd_data = 0;
        bus.alu_insert_bubble = 0; bus.flush = 0;
    endtask

    task automatic issue(input alu_op_t op, input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd);
        bus.id_valid = 1; bus.id_alu_op = op; bus.id_rs1_addr = rs1; bus.id_rs1_data = d1;
        bus.id_rs2_addr = rs2; bus.id_rs2_data = d2; bus.id_rd_addr = rd;
        bus.id_reg_write = 1; bus.id_use_pc = 0; bus.id_use_imm = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        #1;
        n_tests++;
        if (bus.ex_valid !== 1'b0 || bus.alu_op !== ALU_ADD || stall_cycles !== 16'd0 ||
            bus.left_operand !== 32'd0 || bus.ex_reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b op=%0d cnt=%0d left=%h, required 0/0/0/0",
                     bus.ex_valid, bus.alu_op, stall_cycles, bus.left_operand);
        end
        @(negedge clk); rst = 1;
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        issue(ALU_ADD, 5'd5, 32'hAA, 5'd6, 32'h66, 5'd3);
        bus.mem_fwd_we = 1; bus.mem_fwd_rd = 5; bus.mem_fwd_data = 32'h11;
        bus.wb_fwd_we = 1;  bus.wb_fwd_rd = 5;  bus.wb_fwd_data = 32'h22;
        @(negedge clk);
        n_tests++;
        if (bus.left_operand !== 32'h11) begin
            n_fail++; $display("FAIL fwd_mem_priority: left=%h required 00000011", bus.left_operand);
        end
        n_tests++;
        if (bus.right_operand !== 32'h66 || bus.ex_rd_addr !== 5'd3 || bus.ex_reg_write !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_rf_path: right=%h rd=%0d we=%0b required 00000066/3/1",
                     bus.right_operand, bus.ex_rd_addr, bus.ex_reg_write);
        end
        bus.mem_fwd_we = 0;
        @(negedge clk);
        n_tests++;
        if (bus.left_operand !== 32'h22) begin
            n_fail++; $display("FAIL fwd_wb: left=%h required 00000022", bus.left_operand);
        end
        bus.id_rs1_addr = 0; bus.id_rs1_data = 32'h55;
        bus.mem_fwd_we = 1; bus.mem_fwd_rd = 0; bus.wb_fwd_rd = 0;
        @(negedge clk);
        n_tests++;
        if (bus.left_operand !== 32'h0) begin
            n_fail++; $display("FAIL fwd_x0: left=%h required 00000000", bus.left_operand);
        end
        idle_inputs();
    endtask

    task automatic test_selects();
        @(negedge clk);
        issue(ALU_ADD, 5'd1, 32'h1234, 5'd7, 32'h99, 5'd8);
        bus.id_use_pc = 1; bus.id_use_imm = 1; bus.id_pc = 32'h100; bus.id_imm = 32'hFFFFFFFC;
        bus.wb_fwd_we = 1; bus.wb_fwd_rd = 7; bus.wb_fwd_data = 32'h77;
        @(negedge clk);
        n_tests++;
        if (bus.left_operand !== 32'h100 || bus.right_operand !== 32'hFFFFFFFC) begin
            n_fail++;
            $display("FAIL selects: left=%h right=%h required 00000100/fffffffc",
                     bus.left_operand, bus.right_operand);
        end
        n_tests++;
        if (bus.ex_store_data !== 32'h77) begin
            n_fail++; $display("FAIL store_data: got %h required 00000077", bus.ex_store_data);
        end
        idle_inputs();
    endtask

    task automatic test_mul_stall();
        @(negedge clk);
        issue(ALU_MUL, 5'd1, 32'd7, 5'd2, 32'd6, 5'd4);
        @(negedge clk);
        n_tests++;
        if (bus.alu_op !== ALU_MUL || bus.left_operand !== 32'd7 || bus.right_operand !== 32'd6) begin
            n_fail++;
            $display("FAIL mul_capture: op=%0d left=%0d right=%0d required 10/7/6",
                     bus.alu_op, bus.left_operand, bus.right_operand);
        end
        bus.alu_insert_bubble = 1;
        issue(ALU_ADD, 5'd3, 32'h30, 5'd9, 32'h90, 5'd9);
        bus.mem_fwd_we = 1; bus.mem_fwd_rd = 1; bus.mem_fwd_data = 32'hDEAD;
        #1;
        n_tests++;
        if (bus.id_stall !== 1'b1) begin
            n_fail++; $display("FAIL id_stall_rise: got %0b required 1", bus.id_stall);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.alu_op !== ALU_MUL || bus.left_operand !== 32'd7 ||
                bus.right_operand !== 32'd6 || bus.ex_valid !== 1'b1 || bus.id_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL mul_hold[%0d]: op=%0d left=%h right=%h valid=%0b stall=%0b required 10/7/6/1/1",
                         i, bus.alu_op, bus.left_operand, bus.right_operand, bus.ex_valid, bus.id_stall);
            end
        end
        bus.alu_insert_bubble = 0; bus.mem_fwd_we = 0;
        #1;
        n_tests++;
        if (bus.id_stall !== 1'b0) begin
            n_fail++; $display("FAIL id_stall_fall: got %0b required 0", bus.id_stall);
        end
        @(negedge clk);
        n_tests++;
        if (bus.alu_op !== ALU_ADD || bus.left_operand !== 32'h30 || bus.ex_rd_addr !== 5'd9) begin
            n_fail++;
            $display("FAIL mul_next_capture: op=%0d left=%h rd=%0d required 0/00000030/9",
                     bus.alu_op, bus.left_operand, bus.ex_rd_addr);
        end
        n_tests++;
        if (stall_cycles !== 16'd5) begin
            n_fail++; $display("FAIL stall_count: got %0d required 5", stall_cycles);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        @(negedge clk);
        issue(ALU_MUL, 5'd1, 32'd3, 5'd2, 32'd4, 5'd5);
        @(negedge clk);
        bus.alu_insert_bubble = 1; bus.flush = 1;
        issue(ALU_SUB, 5'd3, 32'h33, 5'd4, 32'h44, 5'd6);
        @(negedge clk);
        n_tests++;
        if (bus.ex_valid !== 1'b0 || bus.alu_op !== ALU_ADD || bus.left_operand !== 32'd0 ||
            bus.ex_reg_write !== 1'b0 || bus.id_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_in_stall: valid=%0b op=%0d left=%h we=%0b stall=%0b required 0/0/0/0/1",
                     bus.ex_valid, bus.alu_op, bus.left_operand, bus.ex_reg_write, bus.id_stall);
        end
        bus.flush = 0;
        @(negedge clk);
        n_tests++;
        if (bus.ex_valid !== 1'b0 || bus.id_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_hold: valid=%0b stall=%0b required 0/1", bus.ex_valid, bus.id_stall);
        end
        bus.alu_insert_bubble = 0;
        @(negedge clk);
        n_tests++;
        if (bus.ex_valid !== 1'b1 || bus.alu_op !== ALU_SUB || bus.left_operand !== 32'h33) begin
            n_fail++;
            $display("FAIL post_flush_capture: valid=%0b op=%0d left=%h required 1/1/00000033",
                     bus.ex_valid, bus.alu_op, bus.left_operand);
        end
        bus.flush = 1;
        @(negedge clk);
        n_tests++;
        if (bus.ex_valid !== 1'b0 || bus.alu_op !== ALU_ADD) begin
            n_fail++;
            $display("FAIL flush_no_stall: valid=%0b op=%0d required 0/0", bus.ex_valid, bus.alu_op);
        end
        idle_inputs();
    endtask

    task automatic test_nop();
        @(negedge clk);
        issue(ALU_XOR, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3);
        @(negedge clk);
        bus.id_valid = 0; bus.id_alu_op = ALU_MUL; bus.id_alu_inv_res = 1;
        @(negedge clk);
        n_tests++;
        if (bus.ex_valid !== 1'b0 || bus.alu_op !== ALU_ADD || bus.ex_reg_write !== 1'b0 ||
            bus.alu_inv_res !== 1'b0 || bus.left_operand !== 32'd0) begin
            n_fail++;
            $display("FAIL invalid_nop: valid=%0b op=%0d we=%0b inv=%0b left=%h required 0/0/0/0/0",
                     bus.ex_valid, bus.alu_op, bus.ex_reg_write, bus.alu_inv_res, bus.left_operand);
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        @(negedge clk);
        bus_sat.alu_insert_bubble = 1;
        repeat (14) @(negedge clk);
        n_tests++;
        if (stall_sat !== 4'd14) begin
            n_fail++; $display("FAIL sat_count14: got %0d required 14", stall_sat);
        end
        @(negedge clk);
        n_tests++;
        if (stall_sat !== 4'd15) begin
            n_fail++; $display("FAIL sat_reach: got %0d required 15", stall_sat);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (stall_sat !== 4'd15) begin
            n_fail++; $display("FAIL sat_hold: got %0d required 15", stall_sat);
        end
        bus_sat.alu_insert_bubble = 0;
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        issue(ALU_MUL, 5'd1, 32'd7, 5'd2, 32'd6, 5'd4);
        @(negedge clk);
        bus.alu_insert_bubble = 1;
        @(posedge clk);
        #2;
        rst = 0;
        #1;
        n_tests++;
        if (bus.ex_valid !== 1'b0 || bus.alu_op !== ALU_ADD || stall_cycles !== 16'd0 ||
            bus.left_operand !== 32'd0 || bus.right_operand !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%0b op=%0d cnt=%0d left=%h right=%h required all 0",
                     bus.ex_valid, bus.alu_op, stall_cycles, bus.left_operand, bus.right_operand);
        end
        n_tests++;
        if (stall_sat !== 4'd0) begin
            n_fail++; $display("FAIL async_reset_sat: got %0d required 0", stall_sat);
        end
        idle_inputs();
        @(negedge clk); rst = 1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        bus_sat.id_valid = 0; bus_sat.id_pc = 0; bus_sat.id_rs1_addr = 0;
        bus_sat.id_rs2_addr = 0; bus_sat.id_rs1_data = 0; bus_sat.id_rs2_data = 0;
        bus_sat.id_imm = 0; bus_sat.id_use_pc = 0; bus_sat.id_use_imm = 0;
        bus_sat.id_alu_op = ALU_ADD; bus_sat.id_alu_inv_res = 0; bus_sat.id_rd_addr = 0;
        bus_sat.id_reg_write = 0; bus_sat.mem_fwd_we = 0; bus_sat.mem_fwd_rd = 0;
        bus_sat.mem_fwd_data = 0; bus_sat.wb_fwd_we = 0; bus_sat.wb_fwd_rd = 0;
        bus_sat.wb_fwd_data = 0; bus_sat.alu_insert_bubble = 0; bus_sat.flush = 0;

        test_reset();
        test_forwarding();
        test_selects();
        test_mul_stall();
        test_flush();
        test_nop();
        test_saturation();
        test_reset_mid_mul();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Captures decoded operands from decode and resolves MEM/WB forwarding at capture time.
- Drives the ALU operand and opcode inputs.
- Freezes while the ALU requests bubbles (multi-cycle MUL), back-pressures decode, and supports flush on redirect.

Parameters:
- STALL_CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds an instruction
- id_pc  in  32  instruction PC
- id_rs1_addr  in  5  source register 1 index
- id_rs2_addr  in  5  source register 2 index
- id_rs1_data  in  32  register-file read data 1
- id_rs2_data  in  32  register-file read data 2
- id_imm  in  32  sign-extended immediate
- id_use_pc  in  1  left operand = PC
- id_use_imm  in  1  right operand = immediate
- id_alu_op  in  alu_op_t  decoded ALU operation
- id_alu_inv_res  in  1  invert ALU result
- id_rd_addr  in  5  destination register
- id_reg_write  in  1  instruction writes rd
- mem_fwd_we  in  1  MEM-stage instruction writes rd
- mem_fwd_rd  in  5  MEM-stage rd
- mem_fwd_data  in  32  MEM-stage result
- wb_fwd_we  in  1  WB-stage writes rd
- wb_fwd_rd  in  5  WB-stage rd
- wb_fwd_data  in  32  WB-stage result
- alu_insert_bubble  in  1  ALU stall request (combinational from ALU)
- flush  in  1  squash EX-slot contents (branch/jump redirect)
- left_operand  out  32  to ALU
- right_operand  out  32  to ALU
- alu_op  out  alu_op_t  to ALU
- alu_inv_res  out  1  to ALU
- ex_valid  out  1  EX slot valid
- ex_rd_addr  out  5  destination register
- ex_reg_write  out  1  write enable, qualified by ex_valid
- ex_store_data  out  32  forwarded rs2 value, for stores
- id_stall  out  1  decode must hold its slot
- stall_cycles  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst=0, async) clears all of the following:
  - ex_valid, reg_write, rd, operands, store data, pc, imm, selects, inv_res, stall_cycles
  - alu_op=ALU_ADD
- id_stall = alu_insert_bubble (combinational, same cycle).
- Register update priority, each posedge:
  - flush=1: load NOP (ex_valid=0, alu_op=ALU_ADD, inv=0, reg_write=0, all data 0).
  - Else if alu_insert_bubble=1: hold every register unchanged.
  - Else: capture the decode slot. If id_valid=0, load NOP.
- Forwarding, per source, applied at capture only (no refresh while held):
  - addr==0 gives 0.
  - Else if mem_fwd_we && mem_fwd_rd==addr, use mem_fwd_data.
  - Else if wb_fwd_we && wb_fwd_rd==addr, use wb_fwd_data.
  - Else use the register-file data.
  - MEM beats WB when both match.
- Stored values: rs1_val, rs2_val, pc, imm, use_pc, use_imm.
- Output muxes (combinational from registers):
  - left_operand = use_pc ? pc : rs1_val
  - right_operand = use_imm ? imm : rs2_val
  - ex_store_data = rs2_val
- Latency: one cycle from decode to ALU inputs. Operands and alu_op are stable for the entire stall window, as required by the ALU multiplier pipeline.
- An invalid slot always presents ALU_ADD so no spurious MUL bubble sequence starts.
- Flush during an active MUL stall:
  - Contents are squashed immediately.
  - id_stall keeps following alu_insert_bubble until the ALU counter completes.
- flush together with stall: flush wins for contents; the stall still holds decode.
- stall_cycles increments on every cycle with alu_insert_bubble=1 and saturates at all-ones; no wrap.
- ex_reg_write = stored reg_write & ex_valid.

Test Plan:
- Reset mid-operation: assert rst=0 asynchronously mid-MUL -> outputs clear immediately without clk edge; alu_op=ALU_ADD, ex_valid=0, stall_cycles=0.
- Forwarding priority:
  - ADD x3 with rs1=x5, mem_fwd_we=1 rd=5 data=0x11, wb rd=5 data=0x22 -> next cycle left_operand=0x11.
  - Same with mem_fwd_we=0 -> 0x22.
  - rs1=x0 with a matching rd=0 forward -> 0.
- Operand selects: id_use_pc=1, id_use_imm=1, pc=0x100, imm=0xFFFFFFFC -> left=0x100, right=0xFFFFFFFC, ex_store_data = forwarded rs2.
- MUL stall with ALU model: issue MUL 7×6 -> operands and alu_op held while alu_insert_bubble=1, id_stall mirrors it, the following decode instruction is captured only on the first non-bubble edge, stall_cycles +5 per MUL.
- Flush: assert flush while stalled -> ex_valid=0, alu_op=ALU_ADD next edge, id_stall stays 1 until the bubble drops; with id_valid=0 and no flush -> NOP loaded.
- Counter saturation: STALL_CNT_W=4, hold alu_insert_bubble=1 for 20 cycles -> stall_cycles reads 15 and stays 15.
